// File: rtl/plab1_imul_prod_accum.sv
// Product accumulator: sums groups of p_num_prods 32-bit products from the
// multiplier and hands each group sum downstream over a val/rdy interface.

module plab1_imul_prod_accum #(
  parameter int p_num_prods = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [31:0] in_msg,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [31:0] out_msg
);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [7:0] last_cnt = 8'(p_num_prods - 1);
  localparam bit         single   = (p_num_prods == 1);

  state_t      state_r;
  logic [31:0] sum_r;
  logic [7:0]  cnt_r;
  logic        in_go_s;
  logic        out_go_s;

  // While a sum is held, a new product may enter only as the sum drains
  always_comb begin
    in_rdy = 1'b1;
    case (state_r)
      ACC:     in_rdy = 1'b1;
      DONE:    in_rdy = out_rdy;
      default: in_rdy = 1'b1;
    endcase
  end

  assign in_go_s  = in_val && in_rdy;
  assign out_go_s = out_val && out_rdy;
  assign out_val  = (state_r == DONE);
  assign out_msg  = sum_r;

  // Accumulate products and sequence the group / drain handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ACC;
      sum_r   <= 32'd0;
      cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        ACC: begin
          if (in_go_s) begin
            sum_r <= sum_r + in_msg;
            if (cnt_r == last_cnt) begin
              state_r <= DONE;
              cnt_r   <= 8'd0;
            end else begin
              cnt_r   <= cnt_r + 8'd1;
            end
          end
        end
        DONE: begin
          if (out_go_s) begin
            if (in_go_s) begin
              // The incoming product starts the next group in the same cycle
              sum_r <= in_msg;
              if (single) begin
                state_r <= DONE;
                cnt_r   <= 8'd0;
              end else begin
                state_r <= ACC;
                cnt_r   <= 8'd1;
              end
            end else begin
              state_r <= ACC;
              sum_r   <= 32'd0;
              cnt_r   <= 8'd0;
            end
          end
        end
        default: begin
          state_r <= ACC;
          sum_r   <= 32'd0;
          cnt_r   <= 8'd0;
        end
      endcase
    end
  end

  plab1_imul_prod_accum_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .state   (state_r == DONE),
    .cnt     (cnt_r)
  );

endmodule

// Simulation-only companion: handshake X checks and a one-line cycle trace.
module plab1_imul_prod_accum_chk (
  input logic        clk,
  input logic        reset,
  input logic        in_val,
  input logic        in_rdy,
  input logic [31:0] in_msg,
  input logic        out_val,
  input logic        out_rdy,
  input logic [31:0] out_msg,
  input logic        state,
  input logic [7:0]  cnt
);

  // Handshake signals must be known whenever the block is out of reset
  always @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown(in_val))  else $error("in_val is X");
      assert (!$isunknown(in_rdy))  else $error("in_rdy is X");
      assert (!$isunknown(out_val)) else $error("out_val is X");
      assert (!$isunknown(out_rdy)) else $error("out_rdy is X");
    end
  end

  function automatic string port_str(input logic val, input logic rdy,
                                     input logic [31:0] msg);
    if (val && rdy) return $sformatf("%08h", msg);
    else if (val)   return "#       ";
    else            return ".       ";
  endfunction

  function automatic string line_trace();
    return $sformatf("%s > %s(%0d) > %s",
                     port_str(in_val, in_rdy, in_msg),
                     state ? "DONE" : "ACC ", cnt,
                     port_str(out_val, out_rdy, out_msg));
  endfunction

endmodule

// File: tb/tb_plab1_imul_prod_accum.sv
// Scoreboard bench: three accumulators (groups of 4, 2 and 1) driven with
// directed product streams; a monitor checks every drained sum.

module tb_plab1_imul_prod_accum;

  logic        clk = 1'b0;
  logic        reset   [3];
  logic        in_val  [3];
  logic        in_rdy  [3];
  logic [31:0] in_msg  [3];
  logic        out_val [3];
  logic        out_rdy [3];
  logic [31:0] out_msg [3];

  typedef struct {
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  plab1_imul_prod_accum #(.p_num_prods(4)) u_dut0 (
    .clk(clk), .reset(reset[0]), .in_val(in_val[0]), .in_rdy(in_rdy[0]),
    .in_msg(in_msg[0]), .out_val(out_val[0]), .out_rdy(out_rdy[0]),
    .out_msg(out_msg[0]));

  plab1_imul_prod_accum #(.p_num_prods(2)) u_dut1 (
    .clk(clk), .reset(reset[1]), .in_val(in_val[1]), .in_rdy(in_rdy[1]),
    .in_msg(in_msg[1]), .out_val(out_val[1]), .out_rdy(out_rdy[1]),
    .out_msg(out_msg[1]));

  plab1_imul_prod_accum #(.p_num_prods(1)) u_dut2 (
    .clk(clk), .reset(reset[2]), .in_val(in_val[2]), .in_rdy(in_rdy[2]),
    .in_msg(in_msg[2]), .out_val(out_val[2]), .out_rdy(out_rdy[2]),
    .out_msg(out_msg[2]));

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sum(input int idx, input logic [31:0] val);
    exp_t e;
    e.idx = idx;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic send(input int idx, input logic [31:0] m);
    in_val[idx] = 1'b1;
    in_msg[idx] = m;
    tick();
    in_val[idx] = 1'b0;
  endtask

  // Drained sums are compared against the scoreboard in issue order
  always @(negedge clk) begin
    $display("%s", u_dut0.u_chk.line_trace());
    for (int i = 0; i < 3; i++) begin
      if (reset[i] === 1'b0 && out_val[i] === 1'b1 && out_rdy[i] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sum: dut%0d emitted %08h, none expected", i, out_msg[i]);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("sum_dut%0d_source", i), 32'(i), 32'(mon_e.idx));
          check($sformatf("sum_dut%0d_value", i), out_msg[i], mon_e.val);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      reset[i]   = 1'b1;
      in_val[i]  = 1'b0;
      in_msg[i]  = 32'd0;
      out_rdy[i] = 1'b0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_out_val%0d", i), 32'(out_val[i]), 32'd0);
      check($sformatf("reset_in_rdy%0d", i), 32'(in_rdy[i]), 32'd1);
      check($sformatf("reset_out_msg%0d", i), out_msg[i], 32'd0);
      reset[i] = 1'b0;
    end
    tick();

    // Group of four, 1+2+3+4, drained immediately
    out_rdy[0] = 1'b1;
    expect_sum(0, 32'd10);
    send(0, 32'd1);
    send(0, 32'd2);
    send(0, 32'd3);
    check("pre_last_out_val", 32'(out_val[0]), 32'd0);
    send(0, 32'd4);
    check("latency_out_val", 32'(out_val[0]), 32'd1);
    check("latency_out_msg", out_msg[0], 32'd10);
    tick();
    check("drained_out_val", 32'(out_val[0]), 32'd0);

    // Back-pressure: sum 26 held five cycles while a product is offered
    out_rdy[0] = 1'b0;
    send(0, 32'd5);
    send(0, 32'd6);
    send(0, 32'd7);
    send(0, 32'd8);
    in_val[0] = 1'b1;
    in_msg[0] = 32'd100;
    for (int k = 0; k < 5; k++) begin
      check("stall_out_val", 32'(out_val[0]), 32'd1);
      check("stall_out_msg", out_msg[0], 32'd26);
      check("stall_in_rdy", 32'(in_rdy[0]), 32'd0);
      tick();
    end
    in_val[0]  = 1'b0;
    out_rdy[0] = 1'b1;
    expect_sum(0, 32'd26);
    tick();
    expect_sum(0, 32'd8);
    send(0, 32'd2);
    send(0, 32'd2);
    send(0, 32'd2);
    send(0, 32'd2);
    tick();

    // Groups of two, continuous stream: no bubble between groups
    out_rdy[1] = 1'b1;
    expect_sum(1, 32'd11);
    expect_sum(1, 32'd15);
    send(1, 32'd5);
    send(1, 32'd6);
    check("stream_out_val", 32'(out_val[1]), 32'd1);
    check("stream_in_rdy", 32'(in_rdy[1]), 32'd1);
    send(1, 32'd7);
    check("stream_refill_out_val", 32'(out_val[1]), 32'd0);
    send(1, 32'd8);
    check("stream_second_sum", out_msg[1], 32'd15);
    tick();

    // Modular wrap
    expect_sum(1, 32'h0000_0002);
    send(1, 32'hFFFF_FFFF);
    send(1, 32'h0000_0003);
    check("wrap_out_msg", out_msg[1], 32'h0000_0002);
    tick();

    // Reset mid-group discards the partial sum and overrides an offered product
    send(0, 32'd7);
    send(0, 32'd7);
    reset[0]  = 1'b1;
    in_val[0] = 1'b1;
    in_msg[0] = 32'd50;
    tick();
    reset[0]  = 1'b0;
    in_val[0] = 1'b0;
    check("midreset_out_val", 32'(out_val[0]), 32'd0);
    check("midreset_in_rdy", 32'(in_rdy[0]), 32'd1);
    check("midreset_out_msg", out_msg[0], 32'd0);
    expect_sum(0, 32'd4);
    send(0, 32'd1);
    send(0, 32'd1);
    send(0, 32'd1);
    send(0, 32'd1);
    tick();

    // Single-product groups: stays in DONE across the simultaneous handshake
    out_rdy[2] = 1'b1;
    expect_sum(2, 32'd9);
    expect_sum(2, 32'd10);
    send(2, 32'd9);
    check("n1_first_out_msg", out_msg[2], 32'd9);
    check("n1_first_in_rdy", 32'(in_rdy[2]), 32'd1);
    send(2, 32'd10);
    check("n1_stay_done", 32'(out_val[2]), 32'd1);
    check("n1_second_out_msg", out_msg[2], 32'd10);
    tick();
    check("n1_drained", 32'(out_val[2]), 32'd0);
    tick();
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d sums still pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
